// File: rtl/pa_idu_gpr_issue_ctrl_pkg.sv
// Shared GPR scoreboard encodings (busy states, stall causes) and ID/EX payload type
// used by the ID-stage issue control and the GPR register block.
package pa_idu_gpr_issue_ctrl_pkg;

  localparam logic [2:0] BUSY_IDLE = 3'b000;
  localparam logic [2:0] BUSY1     = 3'b001;
  localparam logic [2:0] BUSY_LSU1 = 3'b010;
  localparam logic [2:0] BUSY_DIV1 = 3'b011;
  localparam logic [2:0] BUSY2     = 3'b100;
  localparam logic [2:0] BUSY_LSU2 = 3'b110;
  localparam logic [2:0] BUSY_DIV2 = 3'b111;

  localparam logic [1:0] STALL_RUN     = 2'b00;
  localparam logic [1:0] STALL_DEP_LSU = 2'b01;
  localparam logic [1:0] STALL_DEP_DIV = 2'b10;
  localparam logic [1:0] STALL_EX_BLK  = 2'b11;

  typedef struct packed {
    logic [31:0] src0;
    logic [31:0] src1;
    logic [4:0]  rd;
    logic        ld;
    logic        div;
  } ex_payload_t;

  function automatic logic is_lsu_busy(input logic [2:0] st);
    return (st == BUSY_LSU1) || (st == BUSY_LSU2);
  endfunction

  function automatic logic is_div_busy(input logic [2:0] st);
    return (st == BUSY_DIV1) || (st == BUSY_DIV2);
  endfunction

endpackage

// File: rtl/pa_idu_gpr_src_rd.sv
// Single source-operand read port: selects a GPR's data and scoreboard state and
// reports whether the operand is usable this cycle and which producer blocks it.
module pa_idu_gpr_src_rd
  import pa_idu_gpr_issue_ctrl_pkg::*;
#(
  parameter int NUM_REG = 32
) (
  input  logic [4:0]            idx_i,
  input  logic                  vld_i,
  input  logic [NUM_REG*3-1:0]  busy_flat_i,
  input  logic [NUM_REG*32-1:0] dout_flat_i,
  input  logic [NUM_REG-1:0]    wb_in_i,
  output logic [31:0]           data_o,
  output logic                  rdy_o,
  output logic                  is_lsu_o,
  output logic                  is_div_o
);

  logic [2:0]  busyArr [NUM_REG];
  logic [31:0] doutArr [NUM_REG];

  for (genvar g = 0; g < NUM_REG; g++) begin : g_unpack
    assign busyArr[g] = busy_flat_i[3*g +: 3];
    assign doutArr[g] = dout_flat_i[32*g +: 32];
  end

  logic       isZero;
  logic [2:0] busySt;
  logic       blocked;

  assign isZero  = (idx_i == 5'd0);
  assign busySt  = busyArr[idx_i];
  // reg_dout already carries a same-cycle write-in, so wb_in clears any busy state
  assign blocked = ~isZero & vld_i & (busySt != BUSY_IDLE) & ~wb_in_i[idx_i];

  assign rdy_o    = ~blocked;
  assign data_o   = isZero ? 32'd0 : doutArr[idx_i];
  assign is_lsu_o = blocked & is_lsu_busy(busySt);
  assign is_div_o = blocked & is_div_busy(busySt);

endmodule

// File: rtl/pa_idu_gpr_issue_ctrl.sv
// ID-stage operand read / issue control: hazard checks against the GPR scoreboard,
// ID/EX operand register, stall-cause FSM and saturating dependency-stall counter.
module pa_idu_gpr_issue_ctrl
  import pa_idu_gpr_issue_ctrl_pkg::*;
#(
  parameter int NUM_REG = 32,
  parameter int CNT_W   = 16
) (
  input  logic                  reg_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  id_inst_vld,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic [4:0]            id_rd,
  input  logic                  id_rs1_vld,
  input  logic                  id_rs2_vld,
  input  logic                  id_rd_vld,
  input  logic                  id_ld_inst,
  input  logic                  id_div_inst,
  input  logic [NUM_REG*3-1:0]  reg_busy_st_flat,
  input  logic [NUM_REG*32-1:0] reg_dout_flat,
  input  logic [NUM_REG-1:0]    reg_wb_in,
  input  logic                  ex_ready,
  input  logic                  rtu_idu_flush_fe,
  input  logic                  rtu_idu_ex1_int_dis_stall_req,
  input  logic                  perf_clr,
  output logic                  id_inst_ready,
  output logic [NUM_REG-1:0]    reg_write_is_vec,
  output logic                  ex_vld,
  output logic [31:0]           ex_src0,
  output logic [31:0]           ex_src1,
  output logic [4:0]            ex_rd,
  output logic                  ex_ld,
  output logic                  ex_div,
  output logic [1:0]            stall_cause,
  output logic [CNT_W-1:0]      dep_stall_cnt
);

  logic [31:0] src1Data, src2Data;
  logic        src1Rdy, src2Rdy;
  logic        src1Lsu, src2Lsu, src1Div, src2Div;

  pa_idu_gpr_src_rd #(.NUM_REG(NUM_REG)) u_rs1_rd (
    .idx_i(id_rs1), .vld_i(id_rs1_vld),
    .busy_flat_i(reg_busy_st_flat), .dout_flat_i(reg_dout_flat), .wb_in_i(reg_wb_in),
    .data_o(src1Data), .rdy_o(src1Rdy), .is_lsu_o(src1Lsu), .is_div_o(src1Div)
  );

  pa_idu_gpr_src_rd #(.NUM_REG(NUM_REG)) u_rs2_rd (
    .idx_i(id_rs2), .vld_i(id_rs2_vld),
    .busy_flat_i(reg_busy_st_flat), .dout_flat_i(reg_dout_flat), .wb_in_i(reg_wb_in),
    .data_o(src2Data), .rdy_o(src2Rdy), .is_lsu_o(src2Lsu), .is_div_o(src2Div)
  );

  logic        exVld_q;
  ex_payload_t exPay_q;
  logic [1:0]  cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Only second-stage producers block a re-write of rd; first-stage ones retire in order
  logic [2:0] rdBusy;
  logic       waw, wawLsu, wawDiv;

  assign rdBusy = reg_busy_st_flat[3*id_rd +: 3];
  assign waw    = id_rd_vld & (id_rd != 5'd0) & ~reg_wb_in[id_rd] &
                  ((rdBusy == BUSY2) | (rdBusy == BUSY_LSU2) | (rdBusy == BUSY_DIV2));
  assign wawLsu = waw & (rdBusy == BUSY_LSU2);
  assign wawDiv = waw & (rdBusy == BUSY_DIV2);

  logic exFree, issue;

  assign exFree = ~exVld_q | ex_ready;
  assign issue  = id_inst_vld & src1Rdy & src2Rdy & ~waw & exFree &
                  ~rtu_idu_flush_fe & ~rtu_idu_ex1_int_dis_stall_req;

  assign id_inst_ready = issue;

  always_comb begin
    reg_write_is_vec = '0;
    if (issue & id_rd_vld & (id_rd != 5'd0)) begin
      reg_write_is_vec[id_rd] = 1'b1;
    end
  end

  logic hazLsu, hazDiv, hazOther;

  assign hazLsu   = src1Lsu | src2Lsu | wawLsu;
  assign hazDiv   = src1Div | src2Div | wawDiv;
  assign hazOther = (~src1Rdy & ~src1Lsu & ~src1Div) | (~src2Rdy & ~src2Lsu & ~src2Div) |
                    (waw & ~wawLsu & ~wawDiv) | rtu_idu_ex1_int_dis_stall_req;

  // Stall cause names the dominant reason the held instruction did not issue
  always_comb begin
    cause_d = STALL_EX_BLK;
    if (rtu_idu_flush_fe | ~id_inst_vld | issue) begin
      cause_d = STALL_RUN;
    end else if (hazLsu) begin
      cause_d = STALL_DEP_LSU;
    end else if (hazDiv) begin
      cause_d = STALL_DEP_DIV;
    end else if (hazOther) begin
      cause_d = STALL_DEP_LSU;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (perf_clr) begin
      cnt_d = '0;
    end else if (id_inst_vld & ~issue & ~rtu_idu_flush_fe & (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge reg_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      exVld_q <= 1'b0;
      exPay_q <= '0;
      cause_q <= STALL_RUN;
      cnt_q   <= '0;
    end else begin
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      if (rtu_idu_flush_fe) begin
        exVld_q <= 1'b0;
      end else if (issue) begin
        exVld_q      <= 1'b1;
        exPay_q.src0 <= src1Data;
        exPay_q.src1 <= src2Data;
        exPay_q.rd   <= id_rd;
        exPay_q.ld   <= id_ld_inst;
        exPay_q.div  <= id_div_inst;
      end else if (ex_ready) begin
        exVld_q <= 1'b0;
      end
    end
  end

  assign ex_vld        = exVld_q;
  assign ex_src0       = exPay_q.src0;
  assign ex_src1       = exPay_q.src1;
  assign ex_rd         = exPay_q.rd;
  assign ex_ld         = exPay_q.ld;
  assign ex_div        = exPay_q.div;
  assign stall_cause   = cause_q;
  assign dep_stall_cnt = cnt_q;

endmodule

// File: tb/tb_pa_idu_gpr_issue_ctrl.sv
// Bench for pa_idu_gpr_issue_ctrl: directed scenarios then random traffic, all checked
// against a behavioural model; a narrow-counter instance exercises saturation cheaply.
module tb_pa_idu_gpr_issue_ctrl;

  logic        clk = 1'b0;
  logic        cpuRstB;
  logic        idInstVld;
  logic [4:0]  idRs1, idRs2, idRd;
  logic        idRs1Vld, idRs2Vld, idRdVld, idLdInst, idDivInst;
  logic [95:0]   busyFlat;
  logic [1023:0] doutFlat;
  logic [31:0] wbIn;
  logic        exReady, flush, intDis, perfClr;

  logic        idInstReady, exVld, exLd, exDiv;
  logic [31:0] regWriteIsVec, exSrc0, exSrc1;
  logic [4:0]  exRd;
  logic [1:0]  stallCause;
  logic [15:0] depStallCnt;

  logic        sReady, sExVld, sExLd, sExDiv;
  logic [31:0] sVec, sSrc0, sSrc1;
  logic [4:0]  sRd;
  logic [1:0]  sCause;
  logic [3:0]  sCnt;

  logic [2:0]  busyArr [32];
  logic [31:0] doutArr [32];

  int compared = 0;
  int mismatched = 0;

  // model state
  logic        mExVld, mLd, mDiv;
  logic [31:0] mSrc0, mSrc1;
  logic [4:0]  mRd;
  logic [1:0]  mCause;
  logic [15:0] mCnt;
  logic [3:0]  mCntSmall;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      busyFlat[3*i +: 3]   = busyArr[i];
      doutFlat[32*i +: 32] = doutArr[i];
    end
  end

  pa_idu_gpr_issue_ctrl #(.NUM_REG(32), .CNT_W(16)) dut (
    .reg_cpuclk(clk), .cpurst_b(cpuRstB), .id_inst_vld(idInstVld),
    .id_rs1(idRs1), .id_rs2(idRs2), .id_rd(idRd),
    .id_rs1_vld(idRs1Vld), .id_rs2_vld(idRs2Vld), .id_rd_vld(idRdVld),
    .id_ld_inst(idLdInst), .id_div_inst(idDivInst),
    .reg_busy_st_flat(busyFlat), .reg_dout_flat(doutFlat), .reg_wb_in(wbIn),
    .ex_ready(exReady), .rtu_idu_flush_fe(flush), .rtu_idu_ex1_int_dis_stall_req(intDis),
    .perf_clr(perfClr), .id_inst_ready(idInstReady), .reg_write_is_vec(regWriteIsVec),
    .ex_vld(exVld), .ex_src0(exSrc0), .ex_src1(exSrc1), .ex_rd(exRd),
    .ex_ld(exLd), .ex_div(exDiv), .stall_cause(stallCause), .dep_stall_cnt(depStallCnt)
  );

  pa_idu_gpr_issue_ctrl #(.NUM_REG(32), .CNT_W(4)) dutSmall (
    .reg_cpuclk(clk), .cpurst_b(cpuRstB), .id_inst_vld(idInstVld),
    .id_rs1(idRs1), .id_rs2(idRs2), .id_rd(idRd),
    .id_rs1_vld(idRs1Vld), .id_rs2_vld(idRs2Vld), .id_rd_vld(idRdVld),
    .id_ld_inst(idLdInst), .id_div_inst(idDivInst),
    .reg_busy_st_flat(busyFlat), .reg_dout_flat(doutFlat), .reg_wb_in(wbIn),
    .ex_ready(exReady), .rtu_idu_flush_fe(flush), .rtu_idu_ex1_int_dis_stall_req(intDis),
    .perf_clr(perfClr), .id_inst_ready(sReady), .reg_write_is_vec(sVec),
    .ex_vld(sExVld), .ex_src0(sSrc0), .ex_src1(sSrc1), .ex_rd(sRd),
    .ex_ld(sExLd), .ex_div(sExDiv), .stall_cause(sCause), .dep_stall_cnt(sCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // A source is usable if it is x0, unused, idle in the scoreboard, or being written now
  function automatic bit srcOk(input logic [4:0] idx, input logic vld);
    return (idx == 5'd0) || !vld || (busyArr[idx] == 3'd0) || wbIn[idx];
  endfunction

  function automatic bit wawBlock();
    return idRdVld && (idRd != 5'd0) && !wbIn[idRd] && (busyArr[idRd] inside {3'd4, 3'd6, 3'd7});
  endfunction

  function automatic bit modelIssue();
    return idInstVld && srcOk(idRs1, idRs1Vld) && srcOk(idRs2, idRs2Vld) && !wawBlock() &&
           (!mExVld || exReady) && !flush && !intDis;
  endfunction

  function automatic logic [1:0] modelCause();
    logic [2:0] blockers[$];
    bit hasLsu = 0;
    bit hasDiv = 0;
    if (flush || !idInstVld || modelIssue()) return 2'd0;
    if (!srcOk(idRs1, idRs1Vld)) blockers.push_back(busyArr[idRs1]);
    if (!srcOk(idRs2, idRs2Vld)) blockers.push_back(busyArr[idRs2]);
    if (wawBlock()) blockers.push_back(busyArr[idRd]);
    foreach (blockers[k]) begin
      if (blockers[k] inside {3'd2, 3'd6}) hasLsu = 1;
      if (blockers[k] inside {3'd3, 3'd7}) hasDiv = 1;
    end
    if (hasLsu) return 2'd1;
    if (hasDiv) return 2'd2;
    if (blockers.size() > 0 || intDis) return 2'd1;
    return 2'd3;
  endfunction

  function automatic logic [31:0] readData(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : doutArr[idx];
  endfunction

  task automatic modelReset();
    mExVld = 0; mSrc0 = 0; mSrc1 = 0; mRd = 0; mLd = 0; mDiv = 0;
    mCause = 0; mCnt = 0; mCntSmall = 0;
  endtask

  // One clock cycle: check everything against the model, then advance the model over the edge
  task automatic applyStimulus(input string tag);
    bit iss;
    bit stall;
    logic [31:0] expVec;
    logic [1:0] nextCause;
    #1;
    if (!cpuRstB) modelReset();
    iss = modelIssue();
    expVec = 32'd0;
    if (iss && idRdVld && idRd != 5'd0) expVec[idRd] = 1'b1;
    checkOutput({tag, ".ready"}, {31'd0, idInstReady}, {31'd0, iss});
    checkOutput({tag, ".wrvec"}, regWriteIsVec, expVec);
    checkOutput({tag, ".exvld"}, {31'd0, exVld}, {31'd0, mExVld});
    checkOutput({tag, ".src0"}, exSrc0, mSrc0);
    checkOutput({tag, ".src1"}, exSrc1, mSrc1);
    checkOutput({tag, ".rd_ld_div"}, {25'd0, exRd, exLd, exDiv}, {25'd0, mRd, mLd, mDiv});
    checkOutput({tag, ".cause"}, {30'd0, stallCause}, {30'd0, mCause});
    checkOutput({tag, ".cnt"}, {16'd0, depStallCnt}, {16'd0, mCnt});
    checkOutput({tag, ".cnt4"}, {28'd0, sCnt}, {28'd0, mCntSmall});
    nextCause = modelCause();
    stall = idInstVld && !iss && !flush;
    @(posedge clk);
    if (!cpuRstB) begin
      modelReset();
    end else begin
      mCause = nextCause;
      if (perfClr) begin
        mCnt = 0; mCntSmall = 0;
      end else if (stall) begin
        if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
        if (mCntSmall != 4'hF) mCntSmall = mCntSmall + 4'd1;
      end
      if (flush) begin
        mExVld = 0;
      end else if (iss) begin
        mExVld = 1;
        mSrc0 = readData(idRs1); mSrc1 = readData(idRs2);
        mRd = idRd; mLd = idLdInst; mDiv = idDivInst;
      end else if (exReady) begin
        mExVld = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic quietInputs();
    idInstVld = 0; idRs1 = 0; idRs2 = 0; idRd = 0;
    idRs1Vld = 0; idRs2Vld = 0; idRdVld = 0; idLdInst = 0; idDivInst = 0;
    exReady = 1; flush = 0; intDis = 0; perfClr = 0; wbIn = 32'd0;
    for (int i = 0; i < 32; i++) begin
      busyArr[i] = 3'd0;
      doutArr[i] = 32'h1000_0000 + i;
    end
  endtask

  task automatic setInst(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic ld, input logic div);
    idInstVld = 1; idRs1 = rs1; idRs2 = rs2; idRd = rd;
    idRs1Vld = 1; idRs2Vld = 1; idRdVld = 1; idLdInst = ld; idDivInst = div;
  endtask

  task automatic randomizeInputs();
    logic [2:0] stateSet [7];
    stateSet = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    for (int i = 0; i < 32; i++) begin
      busyArr[i] = ($urandom_range(0, 2) == 0) ? stateSet[$urandom_range(1, 6)] : 3'd0;
      doutArr[i] = $urandom;
      wbIn[i]    = ($urandom_range(0, 7) == 0);
    end
    idInstVld = ($urandom_range(0, 4) != 0);
    idRs1 = 5'($urandom_range(0, 31)); idRs2 = 5'($urandom_range(0, 31));
    idRd  = 5'($urandom_range(0, 31));
    idRs1Vld = $urandom_range(0, 1) != 0; idRs2Vld = $urandom_range(0, 1) != 0;
    idRdVld = $urandom_range(0, 1) != 0;
    idLdInst = $urandom_range(0, 1) != 0; idDivInst = $urandom_range(0, 1) != 0;
    exReady = ($urandom_range(0, 3) != 0);
    flush   = ($urandom_range(0, 19) == 0);
    intDis  = ($urandom_range(0, 19) == 0);
    perfClr = ($urandom_range(0, 49) == 0);
    cpuRstB = ($urandom_range(0, 199) != 0);
  endtask

  initial begin
    cpuRstB = 0;
    quietInputs();
    modelReset();
    #2;
    applyStimulus("reset");
    applyStimulus("reset2");
    cpuRstB = 1;
    applyStimulus("idle");

    // plain issue with ready operand
    doutArr[5] = 32'h1234_5678;
    setInst(5'd5, 5'd0, 5'd3, 1'b0, 1'b0);
    #1 checkOutput("basic.ready_now", {31'd0, idInstReady}, 32'd1);
    applyStimulus("basic");
    quietInputs();
    checkOutput("basic.exvld_next", {31'd0, exVld}, 32'd1);
    checkOutput("basic.src0_next", exSrc0, 32'h1234_5678);
    applyStimulus("drain");

    // RAW on a load result, resolved by write-back in the fourth cycle
    perfClr = 1;
    applyStimulus("clr");
    perfClr = 0;
    setInst(5'd0, 5'd7, 5'd4, 1'b1, 1'b0);
    busyArr[7] = 3'b010;
    for (int c = 0; c < 3; c++) applyStimulus("lsu_stall");
    checkOutput("lsu.cause", {30'd0, stallCause}, 32'd1);
    wbIn[7] = 1'b1;
    applyStimulus("lsu_wb");
    checkOutput("lsu.cnt", {16'd0, depStallCnt}, 32'd3);
    quietInputs();
    applyStimulus("drain2");

    // WAW on a divide in flight
    setInst(5'd1, 5'd2, 5'd9, 1'b0, 1'b1);
    busyArr[9] = 3'b111;
    applyStimulus("div_blk");
    checkOutput("div.cause", {30'd0, stallCause}, 32'd2);
    wbIn[9] = 1'b1;
    #1 checkOutput("div.wrvec", regWriteIsVec, 32'h0000_0200);
    applyStimulus("div_wb");
    quietInputs();

    // EX back-pressure
    setInst(5'd5, 5'd0, 5'd3, 1'b0, 1'b0);
    applyStimulus("exblk_fill");
    exReady = 0;
    doutArr[6] = 32'hAAAA_5555;
    setInst(5'd6, 5'd0, 5'd8, 1'b1, 1'b0);
    applyStimulus("exblk1");
    applyStimulus("exblk2");
    checkOutput("exblk.cause", {30'd0, stallCause}, 32'd3);
    exReady = 1;
    applyStimulus("exblk_go");
    checkOutput("exblk.src0", exSrc0, 32'hAAAA_5555);

    // flush beats an issuable instruction
    flush = 1;
    #1 checkOutput("flush.ready", {31'd0, idInstReady}, 32'd0);
    applyStimulus("flush");
    checkOutput("flush.exvld", {31'd0, exVld}, 32'd0);
    checkOutput("flush.cause", {30'd0, stallCause}, 32'd0);
    quietInputs();

    // x0 is always ready and reads as zero
    busyArr[0] = 3'b110;
    doutArr[0] = 32'hDEAD_BEEF;
    setInst(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    applyStimulus("x0");
    checkOutput("x0.src0", exSrc0, 32'd0);
    quietInputs();

    // reset asserted in the middle of a stall
    setInst(5'd7, 5'd0, 5'd2, 1'b0, 1'b0);
    busyArr[7] = 3'b011;
    applyStimulus("pre_rst1");
    applyStimulus("pre_rst2");
    cpuRstB = 0;
    applyStimulus("mid_rst");
    cpuRstB = 1;
    quietInputs();
    applyStimulus("post_rst");

    for (int n = 0; n < 1500; n++) begin
      randomizeInputs();
      applyStimulus("rand");
    end
    cpuRstB = 1;
    quietInputs();
    applyStimulus("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
